game_clock_gen: RTL and testbench

- Parametrised multi-channel clock/tick generator; successor to the fixed 2/4/8 Hz divider.
- Each channel produces a 50% duty square wave plus a one-cycle tick at its rising edge, from a per-channel runtime-programmable half-period.
- Has a global "faster" boost that halves selected channels' periods glitch-free, a global enable/freeze, and a synchronous phase-realign.
- Feeds tank movement, enemy AI and shell update logic in the game core.

---
 rtl/game_clock_gen_pkg.sv | 10 +
 rtl/game_clock_gen_clock_div_channel.sv | 62 ++++++
 rtl/game_clock_gen.sv | 48 ++++
 tb/tb_game_clock_gen.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/game_clock_gen_pkg.sv
// game_clock_gen_pkg: shared constants and helpers for the multi-channel game clock generator.
package game_clock_gen_pkg;
  localparam int HALF_2HZ = 25000000;
  localparam int HALF_4HZ = 12500000;
  localparam int HALF_8HZ = 6250000;
  localparam int BOOST_SHIFT = 1;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/game_clock_gen_clock_div_channel.sv
// clock_div_channel: one 50% duty divider channel with tick, boundary-latched half-period and shadow config.
module clock_div_channel
  import game_clock_gen_pkg::*;
#(
  parameter int             CNT_W    = 28,
  parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(HALF_2HZ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic             boost_en_i,
  input  logic             realign_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] cfg_half_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             pending_o
);
  function automatic logic [CNT_W-1:0] eff(input logic [CNT_W-1:0] h, input logic b);
    logic [CNT_W-1:0] base, sh;
    base = (h == '0) ? CNT_W'(1) : h;
    sh = base >> BOOST_SHIFT;
    return !b ? base : ((sh == '0) ? CNT_W'(1) : sh);
  endfunction
  logic [CNT_W-1:0] cnt_q, cnt_d, half_q, half_d, eff_q, eff_d, shadow_q, shadow_d, src;
  logic             clk_q, clk_d, tick_q, tick_d, pend_q, pend_d, bnd, load;
  // half_eff only changes on a load, so boost/config never shorten a phase in flight
  always_comb begin
    bnd = cnt_q == eff_q - CNT_W'(1);
    load = realign_i || (enable_i && bnd);
    src = (realign_i && wr_i) ? cfg_half_i : (pend_q ? shadow_q : half_q);
    cnt_d = load ? '0 : (enable_i ? cnt_q + CNT_W'(1) : cnt_q);
    clk_d = realign_i ? 1'b0 : (load ? ~clk_q : clk_q);
    tick_d = !realign_i && load && !clk_q;
    half_d = load ? src : half_q;
    eff_d = load ? eff(src, boost_en_i) : eff_q;
    shadow_d = wr_i ? cfg_half_i : shadow_q;
    pend_d = realign_i ? 1'b0 : (load ? wr_i : (pend_q | wr_i));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
      tick_q <= 1'b0;
      half_q <= DEF_HALF;
      eff_q <= eff(DEF_HALF, 1'b0);
      shadow_q <= DEF_HALF;
      pend_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
      tick_q <= tick_d;
      half_q <= half_d;
      eff_q <= eff_d;
      shadow_q <= shadow_d;
      pend_q <= pend_d;
    end
  end
  assign clk_out_o = clk_q;
  assign tick_o = tick_q;
  assign pending_o = pend_q;
endmodule

// File: rtl/game_clock_gen.sv
// game_clock_gen: parametrised multi-channel square-wave/tick generator with boost, freeze and realign.
module game_clock_gen
  import game_clock_gen_pkg::*;
#(
  parameter int                       NUM_CH       = 3,
  parameter int                       CNT_W        = 28,
  parameter logic [NUM_CH*CNT_W-1:0]  DEFAULT_HALF = {CNT_W'(HALF_8HZ), CNT_W'(HALF_4HZ), CNT_W'(HALF_2HZ)},
  parameter logic [NUM_CH-1:0]        BOOST_MASK   = NUM_CH'(3'b010),
  localparam int                      CH_W         = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              boost_i,
  input  logic              realign_i,
  input  logic              cfg_valid_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [CNT_W-1:0]  cfg_half_i,
  output logic              cfg_ready_o,
  output logic [NUM_CH-1:0] clk_out_o,
  output logic [NUM_CH-1:0] tick_o
);
  logic [NUM_CH-1:0]    pending;
  logic [2**CH_W-1:0]   pend_all;
  // unpopulated channel indices read as ready and writes to them are dropped
  always_comb begin
    pend_all = '0;
    pend_all[NUM_CH-1:0] = pending;
  end
  assign cfg_ready_o = !pend_all[cfg_ch_i];
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clock_div_channel #(
      .CNT_W   (CNT_W),
      .DEF_HALF(DEFAULT_HALF[i*CNT_W +: CNT_W])
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable_i  (enable_i),
      .boost_en_i(boost_i && BOOST_MASK[i]),
      .realign_i (realign_i),
      .wr_i      (cfg_valid_i && cfg_ready_o && (cfg_ch_i == CH_W'(i))),
      .cfg_half_i(cfg_half_i),
      .clk_out_o (clk_out_o[i]),
      .tick_o    (tick_o[i]),
      .pending_o (pending[i])
    );
  end
endmodule

// File: tb/tb_game_clock_gen.sv
// tb_game_clock_gen: two-channel bench with a cycle scoreboard plus hand-timed corner sequences.
module tb_game_clock_gen;
  localparam logic [1:0] MASK = 2'b01;
  logic       clk = 0, rst_n = 0, enable = 1, boost = 0, realign = 0, cfg_valid = 0;
  logic [0:0] cfg_ch = '0;
  logic [7:0] cfg_half = '0;
  logic       cfg_ready;
  logic [1:0] clk_out, tick;

  game_clock_gen #(.NUM_CH(2), .CNT_W(8), .DEFAULT_HALF({8'd3, 8'd5}), .BOOST_MASK(MASK)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .boost_i(boost), .realign_i(realign),
    .cfg_valid_i(cfg_valid), .cfg_ch_i(cfg_ch), .cfg_half_i(cfg_half),
    .cfg_ready_o(cfg_ready), .clk_out_o(clk_out), .tick_o(tick));

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  logic [7:0] m_cnt[2], m_half[2], m_eff[2], m_sh[2];
  logic [1:0] m_clk = '0, m_tick = '0, m_pend = '0, prev = '0;
  logic [3:0] sb[$];
  int first_rise[2] = '{-1, -1}, last_rise[2] = '{-1, -1}, period[2] = '{0, 0};

  typedef struct { logic en, bst, ra; logic [1:0] exp_clk, exp_tick; } vec_t;
  vec_t vecs[10];

  function automatic logic [7:0] f_eff(input logic [7:0] h, input logic b);
    logic [7:0] base;
    base = (h == 0) ? 8'd1 : h;
    if (!b) return base;
    return ((base >> 1) == 0) ? 8'd1 : (base >> 1);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic model_step();
    logic acc;
    logic [7:0] nh;
    acc = cfg_valid && !m_pend[cfg_ch];
    for (int i = 0; i < 2; i++) begin
      logic wr, b, ld;
      wr = acc && (int'(cfg_ch) == i);
      b = boost && MASK[i];
      ld = realign || (enable && (m_cnt[i] == m_eff[i] - 8'd1));
      nh = (realign && wr) ? cfg_half : (m_pend[i] ? m_sh[i] : m_half[i]);
      if (wr) m_sh[i] = cfg_half;
      m_tick[i] = ld && !realign && !m_clk[i];
      if (realign) begin m_cnt[i] = 0; m_clk[i] = 0; end
      else if (ld) begin m_cnt[i] = 0; m_clk[i] = !m_clk[i]; end
      else if (enable) m_cnt[i] = m_cnt[i] + 8'd1;
      if (ld) begin
        m_half[i] = nh;
        m_eff[i] = f_eff(nh, b);
        m_pend[i] = wr && !realign;
      end else if (wr) m_pend[i] = 1'b1;
    end
  endtask

  task automatic step();
    logic [3:0] e, g;
    #1;
    chk("cfg_ready", int'(cfg_ready), int'(!m_pend[cfg_ch]));
    model_step();
    sb.push_back({m_clk, m_tick});
    @(posedge clk);
    #1;
    g = {clk_out, tick};
    e = sb.pop_front();
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL sb cyc=%0d {clk_out,tick} got=%b exp=%b", cyc + 1, g, e);
    end
    cyc++;
    for (int i = 0; i < 2; i++)
      if (clk_out[i] && !prev[i]) begin
        if (last_rise[i] >= 0) period[i] = cyc - last_rise[i];
        if (first_rise[i] < 0) first_rise[i] = cyc;
        last_rise[i] = cyc;
      end
    prev = clk_out;
    @(negedge clk);
  endtask

  task automatic run_until(input int ch, input logic v, output int n);
    n = 0;
    do begin step(); n++; end while (clk_out[ch] !== v && n < 100);
    if (clk_out[ch] !== v) begin
      checks++;
      failures++;
      $display("FAIL timeout ch%0d waiting for %b", ch, v);
    end
  endtask

  initial begin
    int n;
    m_cnt = '{8'd0, 8'd0}; m_half = '{8'd5, 8'd3}; m_eff = '{8'd5, 8'd3}; m_sh = '{8'd5, 8'd3};
    vecs[0] = '{1, 1, 1, 2'b00, 2'b00};
    vecs[1] = '{1, 1, 0, 2'b11, 2'b11};
    vecs[2] = '{1, 1, 0, 2'b00, 2'b00};
    vecs[3] = '{1, 1, 0, 2'b11, 2'b11};
    vecs[4] = '{0, 1, 0, 2'b11, 2'b00};
    vecs[5] = '{0, 1, 0, 2'b11, 2'b00};
    vecs[6] = '{1, 1, 0, 2'b00, 2'b00};
    vecs[7] = '{1, 1, 0, 2'b11, 2'b11};
    vecs[8] = '{1, 1, 1, 2'b00, 2'b00};
    vecs[9] = '{1, 0, 0, 2'b11, 2'b11};
    repeat (2) @(negedge clk);
    chk("reset_clk_out", int'(clk_out), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_ready", int'(cfg_ready), 1);
    rst_n = 1;
    repeat (25) step();
    chk("first_rise_ch0", first_rise[0], 5);
    chk("first_rise_ch1", first_rise[1], 3);
    chk("period_ch0", period[0], 10);
    chk("period_ch1", period[1], 6);
    // handshake: ch1 stalls while pending, ch0 remains writable
    cfg_valid = 1; cfg_ch = 1; cfg_half = 8'd2;
    step();
    cfg_valid = 0; cfg_ch = 1;
    #1 chk("ready_ch1_busy", int'(cfg_ready), 0);
    cfg_valid = 1; cfg_ch = 0; cfg_half = 8'd8;
    #1 chk("ready_ch0_free", int'(cfg_ready), 1);
    step();
    cfg_valid = 0;
    repeat (30) step();
    chk("period_ch1_new", period[1], 4);
    // boost mid high phase
    run_until(0, 0, n);
    run_until(0, 1, n);
    repeat (3) step();
    boost = 1;
    run_until(0, 0, n); chk("boost_high_rest", n, 5);
    run_until(0, 1, n); chk("boost_low", n, 4);
    run_until(0, 0, n); chk("boost_high", n, 4);
    boost = 0;
    run_until(0, 1, n); chk("unboost_low", n, 4);
    run_until(0, 0, n); chk("unboost_high", n, 8);
    // freeze
    run_until(0, 1, n); chk("low_8", n, 8);
    repeat (2) step();
    enable = 0;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("freeze_clk0", int'(clk_out[0]), 1);
      chk("freeze_tick", int'(tick), 0);
    end
    enable = 1;
    run_until(0, 0, n); chk("freeze_resume", n, 6);
    // realign with a pending write and a concurrent write
    cfg_valid = 1; cfg_ch = 0; cfg_half = 8'd6;
    step();
    cfg_ch = 1; realign = 1;
    step();
    cfg_valid = 0; realign = 0;
    chk("realign_clk_out", int'(clk_out), 0);
    run_until(0, 1, n); chk("realign_rise", n, 6);
    chk("realign_together", int'(clk_out), 3);
    // degenerate halves
    boost = 1;
    cfg_valid = 1; cfg_ch = 0; cfg_half = 8'd1;
    step();
    cfg_ch = 1; cfg_half = 8'd0;
    step();
    cfg_valid = 0;
    foreach (vecs[k]) begin
      enable = vecs[k].en; boost = vecs[k].bst; realign = vecs[k].ra;
      step();
      chk($sformatf("vec%0d_clk", k), int'(clk_out), int'(vecs[k].exp_clk));
      chk($sformatf("vec%0d_tick", k), int'(tick), int'(vecs[k].exp_tick));
    end
    realign = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
